add_arbiter: RTL and testbench



---
 rtl/add_arbiter.sv | 106 ++++++++++
 tb/tb_add_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/add_arbiter.sv
// Round-robin arbiter that time-shares one W-bit adder among NREQ requesters.
// The winning requester's operands are summed and held on a valid/ready result port.
module add_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*W-1:0]        x_in,
    input  logic [NREQ*W-1:0]        y_in,
    output logic [NREQ-1:0]          gnt,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [$clog2(NREQ)-1:0]  res_id,
    output logic [W-1:0]             res_sum,
    output logic                     res_carry,
    output logic [15:0]              op_count
);

    localparam int IDW = $clog2(NREQ);

    // Unsigned add returning {carry, sum}; the single adder shared by all requesters.
    function automatic logic [W:0] add_carry(input logic [W-1:0] a, input logic [W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    logic [IDW-1:0]  r_ptr;
    logic            r_valid_p1;
    logic [IDW-1:0]  r_id_p1;
    logic [W-1:0]    r_sum_p1;
    logic            r_carry_p1;
    logic [15:0]     r_count;

    logic            w_free;
    logic            w_found;
    logic            w_fire;
    logic [IDW-1:0]  w_idx;
    logic [IDW:0]    w_cand;
    logic [NREQ-1:0] w_sel;
    logic [W-1:0]    w_x;
    logic [W-1:0]    w_y;
    logic [W:0]      w_add;

    // Stage p0: pick the first pending request at or above ptr, wrapping.
    always_comb begin
        w_free  = !r_valid_p1 || res_ready;
        w_found = 1'b0;
        w_idx   = '0;
        w_cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = {1'b0, r_ptr} + (IDW+1)'(k);
            if (w_cand >= (IDW+1)'(NREQ))
                w_cand = w_cand - (IDW+1)'(NREQ);
            if (!w_found && req[IDW'(w_cand)]) begin
                w_found = 1'b1;
                w_idx   = IDW'(w_cand);
            end
        end
        w_fire = w_free && w_found && !rst;
    end

    always_comb begin
        w_sel = '0;
        w_x   = '0;
        w_y   = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_sel[i] = w_fire && (w_idx == IDW'(i));
            if (w_idx == IDW'(i)) begin
                w_x = x_in[i*W +: W];
                w_y = y_in[i*W +: W];
            end
        end
        w_add = add_carry(w_x, w_y);
    end

    assign gnt = w_sel;

    // Stage p1: result register, round-robin pointer and grant counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr      <= '0;
            r_valid_p1 <= 1'b0;
            r_id_p1    <= '0;
            r_sum_p1   <= '0;
            r_carry_p1 <= 1'b0;
            r_count    <= '0;
        end else if (w_fire) begin
            r_sum_p1   <= w_add[W-1:0];
            r_carry_p1 <= w_add[W];
            r_id_p1    <= w_idx;
            r_valid_p1 <= 1'b1;
            r_ptr      <= (w_idx == IDW'(NREQ-1)) ? '0 : w_idx + 1'b1;
            r_count    <= r_count + 16'd1;
        end else if (r_valid_p1 && res_ready) begin
            r_valid_p1 <= 1'b0;
        end
    end

    assign res_valid = r_valid_p1;
    assign res_id    = r_id_p1;
    assign res_sum   = r_sum_p1;
    assign res_carry = r_carry_p1;
    assign op_count  = r_count;

endmodule

// File: tb/tb_add_arbiter.sv
// Directed bench for add_arbiter: reset, round robin, backpressure, adder sweep, wrap.
module tb_add_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] x_in;
    logic [31:0] y_in;
    logic [3:0]  gnt;
    logic        res_valid;
    logic        res_ready;
    logic [1:0]  res_id;
    logic [7:0]  res_sum;
    logic        res_carry;
    logic [15:0] op_count;

    int n_checks = 0;
    int n_fail   = 0;

    add_arbiter #(.NREQ(4), .W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .x_in      (x_in),
        .y_in      (y_in),
        .gnt       (gnt),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_sum   (res_sum),
        .res_carry (res_carry),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic sample;
        @(negedge clk);
    endtask

    logic [7:0] prev_sum;

    initial begin
        rst = 1'b1; req = 4'b1111; x_in = '0; y_in = '0; res_ready = 1'b1;
        tick;
        sample;
        check("rst_gnt", gnt, 0);
        tick;
        sample;
        check("rst_gnt2", gnt, 0);
        check("rst_valid", res_valid, 0);
        check("rst_count", op_count, 0);

        // Round robin from ptr = 0
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            sample;
            check("rr_gnt", gnt, 32'(4'b0001 << (k % 4)));
            check("rr_count", op_count, k);
            if (k > 0) check("rr_id", res_id, (k - 1) % 4);
            tick;
        end
        check("rr_count_end", op_count, 5);

        // Single requester 2: 200 + 100 = 300 -> sum 44, carry 1
        req = 4'b0100; x_in[16 +: 8] = 8'd200; y_in[16 +: 8] = 8'd100;
        sample;
        check("single_gnt", gnt, 4'b0100);
        tick;
        req = 4'b0000;
        sample;
        check("single_valid", res_valid, 1);
        check("single_id", res_id, 2);
        check("single_sum", res_sum, 44);
        check("single_carry", res_carry, 1);
        tick;
        sample;
        check("drain_valid", res_valid, 0);
        check("drain_sum_hold", res_sum, 44);

        // Backpressure: ptr = 3, so req 0011 grants 0 first
        @(posedge clk); #1;
        req = 4'b0011; x_in[0 +: 8] = 8'd10; y_in[0 +: 8] = 8'd20;
        x_in[8 +: 8] = 8'd5; y_in[8 +: 8] = 8'd6;
        sample;
        check("bp_first_gnt", gnt, 4'b0001);
        tick;
        res_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sample;
            check("bp_gnt", gnt, 0);
            check("bp_valid", res_valid, 1);
            check("bp_id", res_id, 0);
            check("bp_sum", res_sum, 30);
            check("bp_count", op_count, 7);
            tick;
        end
        res_ready = 1'b1;
        sample;
        check("bp_resume_gnt", gnt, 4'b0010);
        tick;
        req = 4'b0000;
        sample;
        check("bp_resume_id", res_id, 1);
        check("bp_resume_sum", res_sum, 11);
        check("bp_resume_count", op_count, 8);
        tick;

        // Adder sweep on requester 1, one grant per cycle
        req = 4'b0010;
        prev_sum = '0;
        for (int x = 0; x <= 30; x++) begin
            for (int y = 0; y <= 30; y++) begin
                x_in[8 +: 8] = 8'(x); y_in[8 +: 8] = 8'(y);
                sample;
                check("sweep_gnt", gnt, 4'b0010);
                if (x != 0 || y != 0) begin
                    check("sweep_sum", res_sum, prev_sum);
                    check("sweep_carry", res_carry, 0);
                    check("sweep_id", res_id, 1);
                end
                prev_sum = 8'(x + y);
                tick;
            end
        end
        sample;
        check("sweep_last_sum", res_sum, 60);
        check("sweep_count", op_count, 969);

        // Mid-operation reset with a result pending
        @(posedge clk); #1;
        check("pre_rst_valid", res_valid, 1);
        rst = 1'b1; req = 4'b1111;
        sample;
        check("rst_mid_gnt", gnt, 0);
        tick;
        sample;
        check("rst_mid_valid", res_valid, 0);
        check("rst_mid_count", op_count, 0);
        check("rst_mid_sum", res_sum, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        sample;
        check("post_rst_gnt", gnt, 4'b0001);

        // Counter wrap after 65536 grants
        for (int k = 0; k < 65535; k++) tick;
        sample;
        check("wrap_pre", op_count, 65535);
        tick;
        sample;
        check("wrap_zero", op_count, 0);
        check("wrap_valid", res_valid, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
